// File: rtl/thinpad_mem_ctrl.sv
// Thinpad BaseRAM/ExtRAM/CPLD-UART controller behind a single req/ack CPU port.
// Latency: SRAM RAM_WAIT+3, UART data UART_WAIT+2 (+TX busy), status/unmapped 1 cycle.
// Backpressure: req is held until the one-cycle ack; UART writes stall while the CPLD transmitter is busy.
module thinpad_mem_ctrl #(
    parameter int          RAM_WAIT       = 1,
    parameter int          UART_WAIT      = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter logic [31:0] EXT_ADDR       = 32'h8040_0000,
    parameter logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8,
    parameter logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    localparam int MAX_WAIT = (RAM_WAIT > UART_WAIT) ? RAM_WAIT : UART_WAIT;
    localparam int CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] RAM_LOAD  = CW'(RAM_WAIT);
    localparam logic [CW-1:0] UART_LOAD = CW'(UART_WAIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_UR     = 3'd4;
    localparam logic [2:0] S_UWW    = 3'd5;
    localparam logic [2:0] S_UW     = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          is_sram;
    logic          is_ext;
    logic          is_wr;
    logic          is_uw;
    logic [19:0]   addr_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;

    logic hit_base, hit_ext, hit_udata, hit_ustat, tx_ready;
    logic sram_act, base_act, ext_act, base_drv, ext_drv, uart_drv;
    logic unused_ok;

    assign hit_base  = (addr[31:22] == BASE_ADDR[31:22]);
    assign hit_ext   = (addr[31:22] == EXT_ADDR[31:22]);
    assign hit_udata = (addr[31:2] == UART_DATA_ADDR[31:2]);
    assign hit_ustat = (addr[31:2] == UART_STAT_ADDR[31:2]);
    assign tx_ready  = uart_tbre & uart_tsre;
    assign unused_ok = &{1'b0, addr[1:0]};

    // Access sequencer: decode in IDLE, walk the phases, latch read data on the last strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_sram <= 1'b0;
            is_ext  <= 1'b0;
            is_wr   <= 1'b0;
            is_uw   <= 1'b0;
            addr_r  <= '0;
            be_r    <= '0;
            wdata_r <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_r  <= addr[21:2];
                        be_r    <= be;
                        wdata_r <= wdata;
                        is_wr   <= we;
                        is_sram <= hit_base | hit_ext;
                        is_ext  <= hit_ext & ~hit_base;
                        is_uw   <= hit_udata & we;
                        rdata   <= '0;
                        if (hit_base || hit_ext) begin
                            state <= S_SETUP;
                        end else if (hit_udata) begin
                            if (!we) begin
                                state <= S_UR;
                                cnt   <= UART_LOAD;
                            end else if (tx_ready) begin
                                state <= S_UW;
                                cnt   <= UART_LOAD;
                            end else begin
                                state <= S_UWW;
                            end
                        end else begin
                            if (hit_ustat && !we) begin
                                rdata <= {30'b0, uart_dataready, tx_ready};
                            end
                            state <= S_DONE;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_STROBE;
                    cnt   <= RAM_LOAD;
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        if (!is_wr) begin
                            rdata <= is_ext ? ext_ram_data : base_ram_data;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_UR: begin
                    if (cnt == '0) begin
                        rdata <= {24'b0, base_ram_data[7:0]};
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_UWW: begin
                    if (tx_ready) begin
                        state <= S_UW;
                        cnt   <= UART_LOAD;
                    end
                end
                S_UW: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pin drive is a pure function of phase and the latched request, so reset releases everything at once.
    always_comb begin
        sram_act = is_sram && (state == S_SETUP || state == S_STROBE || state == S_DONE);
        base_act = sram_act && !is_ext;
        ext_act  = sram_act && is_ext;
        base_drv = base_act && is_wr;
        ext_drv  = ext_act && is_wr;
        uart_drv = (state == S_UW) || (state == S_DONE && is_uw);

        ack           = (state == S_DONE);
        base_ram_addr = addr_r;
        ext_ram_addr  = addr_r;
        base_ram_ce_n = !base_act;
        ext_ram_ce_n  = !ext_act;
        base_ram_oe_n = !(base_act && state == S_STROBE && !is_wr);
        base_ram_we_n = !(base_act && state == S_STROBE && is_wr);
        ext_ram_oe_n  = !(ext_act && state == S_STROBE && !is_wr);
        ext_ram_we_n  = !(ext_act && state == S_STROBE && is_wr);
        base_ram_be_n = base_act ? (is_wr ? ~be_r : 4'b0000) : 4'hF;
        ext_ram_be_n  = ext_act ? (is_wr ? ~be_r : 4'b0000) : 4'hF;
        uart_rdn      = !(state == S_UR);
        uart_wrn      = !(state == S_UW);
    end

    assign base_ram_data = base_drv ? wdata_r :
                           (uart_drv ? {24'h0, wdata_r[7:0]} : 32'hzzzz_zzzz);
    assign ext_ram_data  = ext_drv ? wdata_r : 32'hzzzz_zzzz;

endmodule
